// File: rtl/rt_ibex_pcs_ctrl_pkg.sv
// Shared types and defaults for the PCS context-stack sequencer.
package rt_ibex_pcs_ctrl_pkg;

  localparam int unsigned IrqLevelWidthDef  = 8;
  localparam int unsigned StackDepthDef     = 4;
  localparam int unsigned RestoreTimeoutDef = 8;

  typedef enum logic [1:0] {
    PcsIdle,
    PcsSave,
    PcsRestore
  } pcs_ctrl_state_e;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rt_ibex_pcs_ctrl_if.sv
// Controller/PCS handshake bundle seen by the PCS sequencer.
interface rt_ibex_pcs_ctrl_if #(
  parameter int unsigned IrqLevelWidth = 8,
  parameter int unsigned DepthWidth    = 3
);
  logic                     irq_valid_i;
  logic [IrqLevelWidth-1:0] irq_level_i;
  logic                     irq_take_o;
  logic                     irq_ack_i;
  logic                     mret_id_i;
  logic                     mret_wb_i;
  logic [IrqLevelWidth-1:0] pcs_irq_level_o;
  logic                     pcs_irq_ack_o;
  logic                     pcs_irq_exit_o;
  logic                     pcs_next_mret_o;
  logic                     pcs_restore_done_i;
  logic                     stall_o;
  logic [IrqLevelWidth-1:0] cur_level_o;
  logic [DepthWidth-1:0]    depth_o;
  logic                     err_o;

  modport slave (
    input  irq_valid_i, irq_level_i, irq_ack_i, mret_id_i, mret_wb_i, pcs_restore_done_i,
    output irq_take_o, pcs_irq_level_o, pcs_irq_ack_o, pcs_irq_exit_o, pcs_next_mret_o,
           stall_o, cur_level_o, depth_o, err_o
  );

  modport master (
    output irq_valid_i, irq_level_i, irq_ack_i, mret_id_i, mret_wb_i, pcs_restore_done_i,
    input  irq_take_o, pcs_irq_level_o, pcs_irq_ack_o, pcs_irq_exit_o, pcs_next_mret_o,
           stall_o, cur_level_o, depth_o, err_o
  );
endinterface

// File: rtl/rt_ibex_pcs_level_stack.sv
// Flop-based LIFO of preempted interrupt levels; push and pop are mutually exclusive.
module rt_ibex_pcs_level_stack #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Depth  = 4,
  parameter int unsigned DepthW = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [Width-1:0]  i_data,
  output logic [Width-1:0]  o_top,
  output logic [DepthW-1:0] o_depth,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]  r_mem [Depth];
  logic [DepthW-1:0] r_depth;
  logic [DepthW-1:0] w_top_ptr;

  assign w_top_ptr = r_depth - DepthW'(1);
  assign o_full    = (r_depth == DepthW'(Depth));
  assign o_empty   = (r_depth == '0);
  assign o_depth   = r_depth;
  assign o_top     = r_mem[IdxW'(w_top_ptr)];

  // Full/empty guards keep depth saturating instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_depth <= '0;
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
    end else if (i_push && !o_full) begin
      r_mem[IdxW'(r_depth)] <= i_data;
      r_depth               <= r_depth + DepthW'(1);
    end else if (i_pop && !o_empty) begin
      r_depth <= w_top_ptr;
    end
  end

endmodule

// File: rtl/rt_ibex_pcs_ctrl.sv
// Interrupt-nesting sequencer: drives PCS save/restore pulses and stalls the core meanwhile.
module rt_ibex_pcs_ctrl
  import rt_ibex_pcs_ctrl_pkg::*;
#(
  parameter int unsigned IrqLevelWidth  = IrqLevelWidthDef,
  parameter int unsigned StackDepth     = StackDepthDef,
  parameter int unsigned RestoreTimeout = RestoreTimeoutDef
) (
  input logic               clk_i,
  input logic               rst_ni,
  rt_ibex_pcs_ctrl_if.slave bus
);

  localparam int unsigned DepthW = count_width(StackDepth);
  localparam int unsigned CntW   = count_width(RestoreTimeout);

  pcs_ctrl_state_e          r_state, w_state_next;
  logic [IrqLevelWidth-1:0] r_cur_level, w_cur_level_next;
  logic [CntW-1:0]          r_cnt, w_cnt_next;
  logic                     r_err, w_err_next;
  logic                     r_exit, w_exit_next;

  logic                     w_push, w_pop, w_full, w_empty, w_take;
  logic [IrqLevelWidth-1:0] w_top;
  logic [DepthW-1:0]        w_depth;

  rt_ibex_pcs_level_stack #(
    .Width  (IrqLevelWidth),
    .Depth  (StackDepth),
    .DepthW (DepthW)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_cur_level),
    .o_top   (w_top),
    .o_depth (w_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_take = (r_state == PcsIdle) && bus.irq_valid_i &&
                  (bus.irq_level_i > r_cur_level) && !w_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= PcsIdle;
      r_cur_level <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_exit      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cur_level <= w_cur_level_next;
      r_cnt       <= w_cnt_next;
      r_err       <= w_err_next;
      r_exit      <= w_exit_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cur_level_next = r_cur_level;
    w_cnt_next       = r_cnt;
    w_err_next       = r_err;
    w_exit_next      = 1'b0;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    unique case (r_state)
      PcsIdle: begin
        if (bus.irq_ack_i && bus.mret_wb_i) begin
          // Tail-chain: the returning handler's slot is reused by the new irq.
          w_cur_level_next = bus.irq_level_i;
        end else if (bus.irq_ack_i) begin
          if (w_take) begin
            w_push           = 1'b1;
            w_cur_level_next = bus.irq_level_i;
            w_state_next     = PcsSave;
          end else begin
            w_err_next = 1'b1;
          end
        end else if (bus.mret_wb_i) begin
          if (!w_empty) begin
            w_pop            = 1'b1;
            w_cur_level_next = w_top;
            w_cnt_next       = '0;
            w_exit_next      = 1'b1;
            w_state_next     = PcsRestore;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      PcsSave: begin
        if (bus.irq_ack_i || bus.mret_wb_i) w_err_next = 1'b1;
        w_state_next = PcsIdle;
      end
      PcsRestore: begin
        if (bus.irq_ack_i || bus.mret_wb_i) w_err_next = 1'b1;
        if (bus.pcs_restore_done_i) begin
          w_state_next = PcsIdle;
        end else if (r_cnt == CntW'(RestoreTimeout - 1)) begin
          w_state_next = PcsIdle;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      default: w_state_next = PcsIdle;
    endcase
  end

  assign bus.irq_take_o      = w_take;
  assign bus.pcs_next_mret_o = bus.mret_id_i && !w_empty && (r_state == PcsIdle);
  assign bus.pcs_irq_level_o = r_cur_level;
  assign bus.pcs_irq_ack_o   = (r_state == PcsSave);
  assign bus.pcs_irq_exit_o  = r_exit;
  assign bus.stall_o         = (r_state != PcsIdle);
  assign bus.cur_level_o     = r_cur_level;
  assign bus.depth_o         = w_depth;
  assign bus.err_o           = r_err;

endmodule

// File: tb/tb_rt_ibex_pcs_ctrl.sv
// Scoreboard bench for rt_ibex_pcs_ctrl against a queue-based nesting model.
module tb_rt_ibex_pcs_ctrl;

  localparam int MaxDepth = 4;
  localparam int Timeout  = 8;

  typedef struct {
    bit is_exit;
    int level;
    int depth;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  rt_ibex_pcs_ctrl_if #(.IrqLevelWidth(8), .DepthWidth(3)) bus ();

  rt_ibex_pcs_ctrl #(
    .IrqLevelWidth  (8),
    .StackDepth     (MaxDepth),
    .RestoreTimeout (Timeout)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   m_stk[$];
  int   m_cur = 0;
  bit   m_err = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every PCS pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni && (bus.pcs_irq_ack_o || bus.pcs_irq_exit_o)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: ack=%0b exit=%0b with no pending expectation at %0t",
                 bus.pcs_irq_ack_o, bus.pcs_irq_exit_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_is_exit", int'(bus.pcs_irq_exit_o), int'(e.is_exit));
        chk("pulse_is_ack", int'(bus.pcs_irq_ack_o), int'(!e.is_exit));
        chk("pulse_level", int'(bus.pcs_irq_level_o), e.level);
        chk("pulse_depth", int'(bus.depth_o), e.depth);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    bus.irq_valid_i        = 1'b0;
    bus.irq_level_i        = '0;
    bus.irq_ack_i          = 1'b0;
    bus.mret_id_i          = 1'b0;
    bus.mret_wb_i          = 1'b0;
    bus.pcs_restore_done_i = 1'b0;
  endtask

  task automatic model_reset();
    m_stk.delete();
    sb.delete();
    m_cur = 0;
    m_err = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cur"}, int'(bus.cur_level_o), m_cur);
    chk({tag, "_depth"}, int'(bus.depth_o), m_stk.size());
    chk({tag, "_err"}, int'(bus.err_o), int'(m_err));
    chk({tag, "_stall"}, int'(bus.stall_o), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_take"}, int'(bus.irq_take_o), 0);
    chk({tag, "_ack"}, int'(bus.pcs_irq_ack_o), 0);
    chk({tag, "_exit"}, int'(bus.pcs_irq_exit_o), 0);
    chk({tag, "_stall"}, int'(bus.stall_o), 0);
    chk({tag, "_cur"}, int'(bus.cur_level_o), 0);
    chk({tag, "_depth"}, int'(bus.depth_o), 0);
    chk({tag, "_err"}, int'(bus.err_o), 0);
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_ni = 1'b0;
    step();
    model_reset();
    chk_all_zero("reset");
    rst_ni = 1'b1;
    step();
  endtask

  // Offer an irq; ack it when allowed (or forcibly), optionally retiring an mret during the save.
  task automatic do_irq(input int lvl, input bit force_ack, input bit mret_in_save);
    bit exp_take;
    bus.irq_valid_i = 1'b1;
    bus.irq_level_i = 8'(lvl);
    #1;
    exp_take = (lvl > m_cur) && (m_stk.size() < MaxDepth);
    chk("irq_take", int'(bus.irq_take_o), int'(exp_take));
    if (exp_take || force_ack) begin
      bus.irq_ack_i = 1'b1;
      if (exp_take) begin
        m_stk.push_back(m_cur);
        m_cur = lvl;
        sb.push_back('{1'b0, m_cur, m_stk.size()});
      end else begin
        m_err = 1'b1;
      end
      step();
      clear_inputs();
      if (exp_take) begin
        chk("save_stall", int'(bus.stall_o), 1);
        if (mret_in_save) begin
          bus.mret_wb_i = 1'b1;
          m_err = 1'b1;
        end
        step();
        clear_inputs();
      end
    end else begin
      step();
      clear_inputs();
    end
    chk_idle("after_irq");
  endtask

  // Retire an mret; the PCS reports done in restore cycle done_dly+1.
  task automatic do_mret(input int done_dly);
    int n;
    int exp_n;
    bus.mret_id_i = 1'b1;
    #1;
    chk("next_mret", int'(bus.pcs_next_mret_o), int'(m_stk.size() > 0));
    bus.mret_id_i = 1'b0;
    bus.mret_wb_i = 1'b1;
    if (m_stk.size() == 0) begin
      m_err = 1'b1;
      step();
      clear_inputs();
      chk_idle("spurious_mret");
      return;
    end
    m_cur = m_stk.pop_back();
    sb.push_back('{1'b1, m_cur, m_stk.size()});
    step();
    clear_inputs();
    n = 0;
    while (bus.stall_o && n < 20) begin
      n++;
      if (n == done_dly + 1) bus.pcs_restore_done_i = 1'b1;
      step();
      bus.pcs_restore_done_i = 1'b0;
    end
    exp_n = (done_dly + 1 <= Timeout) ? done_dly + 1 : Timeout;
    if (done_dly + 1 > Timeout) m_err = 1'b1;
    chk("restore_stall_cycles", n, exp_n);
    chk_idle("after_mret");
  endtask

  task automatic do_tail(input int lvl);
    bus.irq_valid_i = 1'b1;
    bus.irq_level_i = 8'(lvl);
    bus.irq_ack_i   = 1'b1;
    bus.mret_wb_i   = 1'b1;
    m_cur = lvl;
    step();
    clear_inputs();
    chk_idle("tail_chain");
  endtask

  task automatic reset_mid_save(input int lvl);
    bus.irq_valid_i = 1'b1;
    bus.irq_level_i = 8'(lvl);
    bus.irq_ack_i   = 1'b1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk_i);
    chk_all_zero("reset_mid_save");
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    @(negedge clk_i);
    apply_reset();

    // Basic take/save and nested restore.
    do_irq(3, 1'b0, 1'b0);
    do_irq(5, 1'b0, 1'b0);
    do_mret(2);
    do_mret(0);

    // Non-preempting levels and a forced ack.
    do_irq(5, 1'b0, 1'b0);
    do_irq(5, 1'b1, 1'b0);
    do_irq(2, 1'b1, 1'b0);
    apply_reset();

    // Full stack blocks any level until one entry pops.
    for (int l = 1; l <= MaxDepth; l++) do_irq(l, 1'b0, 1'b0);
    do_irq(9, 1'b0, 1'b0);
    do_mret(1);
    do_irq(9, 1'b0, 1'b0);
    apply_reset();

    // Tail-chain and unsigned full-width compare.
    do_irq(3, 1'b0, 1'b0);
    do_tail(6);
    do_irq(200, 1'b0, 1'b0);
    do_irq(100, 1'b0, 1'b0);
    do_mret(0);
    apply_reset();

    // Restore timeout, then reset while saving.
    do_irq(3, 1'b0, 1'b0);
    do_mret(20);
    reset_mid_save(4);
    do_mret(0);
    do_irq(1, 1'b0, 1'b1);
    apply_reset();

    for (int i = 0; i < 400; i++) begin
      int op;
      int lvl;
      op  = int'($urandom_range(0, 19));
      lvl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 12));
      if (op < 10)       do_irq(lvl, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      else if (op < 17)  do_mret(int'($urandom_range(0, 10)));
      else if (op < 19)  do_tail(lvl);
      else if ($urandom_range(0, 2) == 0) apply_reset();
      else               reset_mid_save(lvl);
    end

    step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
